// File: rtl/gearbox_rx_pkg.sv
// Shared PCS constants for the receive gearbox: block geometry and sync header codes.
package gearbox_rx_pkg;

    localparam int HEAD_W  = 2;
    localparam int DATA_W  = 64;
    localparam int BLOCK_W = HEAD_W + DATA_W;
    localparam int BUF_W   = 128;
    localparam int FILL_W  = 7;

    localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b10;
    localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b01;

endpackage

// File: rtl/gearbox_rx_if.sv
// SerDes-side word stream plus slip request in, 66-bit blocks out; the gearbox uses the slave modport.
interface gearbox_rx_if;

    logic                                serdes_v_i;
    logic [gearbox_rx_pkg::DATA_W-1:0]   serdes_data_i;
    logic                                slip_i;
    logic                                valid_o;
    logic [gearbox_rx_pkg::HEAD_W-1:0]   head_o;
    logic [gearbox_rx_pkg::DATA_W-1:0]   data_o;

    modport master (
        output serdes_v_i, serdes_data_i, slip_i,
        input  valid_o, head_o, data_o
    );

    modport slave (
        input  serdes_v_i, serdes_data_i, slip_i,
        output valid_o, head_o, data_o
    );

endinterface

// File: rtl/gearbox_rx.sv
// 64-bit to 66-bit receive gearbox with single-bit slip; blocks appear one cycle after the completing word.
// No backpressure: every valid word is absorbed, idle cycles simply hold state.
module gearbox_rx
    import gearbox_rx_pkg::*;
(
    input  logic         clk,
    input  logic         nreset,
    gearbox_rx_if.slave  gb
);

    localparam int WIDE_W = BUF_W + BLOCK_W;

    logic [BUF_W-1:0]  bit_buf;
    logic [FILL_W-1:0] fill;
    logic              sp;

    logic              slip_now;
    logic [DATA_W-1:0] word;
    logic [FILL_W:0]   fill_next;
    logic [WIDE_W-1:0] merged;
    logic              emit;

    // Fill can momentarily reach 129 bits, so the append is computed wider than the stored buffer.
    always_comb begin
        slip_now  = sp | gb.slip_i;
        word      = slip_now ? {1'b0, gb.serdes_data_i[DATA_W-1:1]} : gb.serdes_data_i;
        fill_next = {1'b0, fill} + (FILL_W+1)'(DATA_W) - {{FILL_W{1'b0}}, slip_now};
        merged    = {{BLOCK_W{1'b0}}, bit_buf} | (WIDE_W'(word) << fill);
        emit      = fill_next >= (FILL_W+1)'(BLOCK_W);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            bit_buf    <= '0;
            fill       <= '0;
            sp         <= 1'b0;
            gb.valid_o <= 1'b0;
            gb.head_o  <= '0;
            gb.data_o  <= '0;
        end else begin
            gb.valid_o <= 1'b0;
            if (gb.serdes_v_i) begin
                sp <= 1'b0;
                if (emit) begin
                    gb.valid_o <= 1'b1;
                    gb.head_o  <= merged[HEAD_W-1:0];
                    gb.data_o  <= merged[HEAD_W +: DATA_W];
                    bit_buf    <= merged[BLOCK_W +: BUF_W];
                    fill       <= FILL_W'(fill_next - (FILL_W+1)'(BLOCK_W));
                end else begin
                    bit_buf <= merged[BUF_W-1:0];
                    fill    <= fill_next[FILL_W-1:0];
                end
            end else if (gb.slip_i) begin
                sp <= 1'b1;
            end
        end
    end

endmodule
